// File: rtl/mem_bus_arbiter.sv
// Two-master (IF / MEM) arbiter for a single ack-handshaked memory bus.
// Registers the winning request onto the bus and returns a registered ack, read data and timeout error.
module mem_bus_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [3:0]        dm_sel,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              bus_cyc,
  output logic              bus_stb,
  output logic              bus_we,
  output logic [3:0]        bus_sel,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              bus_err,
  output logic              stallreq_if,
  output logic              stallreq_mem
);

  typedef enum logic [1:0] {IDLE, BUS_IF, BUS_DM, DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t            r_state;
  logic              r_last_dm;
  logic [7:0]        r_cnt;
  logic              r_stb;
  logic              r_we;
  logic [3:0]        r_sel;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic              r_if_ack;
  logic              r_dm_ack;
  logic              r_err;
  logic              w_grant_dm;

  // Under contention dm wins unless it won last time, so the two alternate.
  assign w_grant_dm = dm_req && (!if_req || !r_last_dm);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_last_dm  <= 1'b0;
      r_cnt      <= '0;
      r_stb      <= 1'b0;
      r_we       <= 1'b0;
      r_sel      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
      r_if_ack   <= 1'b0;
      r_dm_ack   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_if_ack <= 1'b0;
      r_dm_ack <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_dm) begin
            r_addr    <= dm_addr;
            r_we      <= dm_we;
            r_sel     <= dm_sel;
            r_wdata   <= dm_wdata;
            r_stb     <= 1'b1;
            r_cnt     <= '0;
            r_last_dm <= 1'b1;
            r_state   <= BUS_DM;
          end else if (if_req) begin
            r_addr    <= if_addr;
            r_we      <= 1'b0;
            r_sel     <= 4'hF;
            r_wdata   <= '0;
            r_stb     <= 1'b1;
            r_cnt     <= '0;
            r_last_dm <= 1'b0;
            r_state   <= BUS_IF;
          end
        end
        BUS_IF, BUS_DM: begin
          if (bus_ack) begin
            r_stb   <= 1'b0;
            r_state <= DONE;
            if (r_state == BUS_IF) begin
              r_if_rdata <= bus_rdata;
              r_if_ack   <= 1'b1;
            end else begin
              if (!r_we) r_dm_rdata <= bus_rdata;
              r_dm_ack <= 1'b1;
            end
          end else if (r_cnt == TO_LAST) begin
            // Abort: the requester still gets its ack so the pipeline unfreezes.
            r_stb   <= 1'b0;
            r_err   <= 1'b1;
            r_state <= DONE;
            if (r_state == BUS_IF) begin
              r_if_rdata <= '0;
              r_if_ack   <= 1'b1;
            end else begin
              r_dm_rdata <= '0;
              r_dm_ack   <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus_cyc      = r_stb;
  assign bus_stb      = r_stb;
  assign bus_we       = r_we;
  assign bus_sel      = r_sel;
  assign bus_addr     = r_addr;
  assign bus_wdata    = r_wdata;
  assign bus_err      = r_err;
  assign if_rdata     = r_if_rdata;
  assign if_ack       = r_if_ack;
  assign dm_rdata     = r_dm_rdata;
  assign dm_ack       = r_dm_ack;
  assign stallreq_if  = if_req & ~r_if_ack;
  assign stallreq_mem = dm_req & ~r_dm_ack;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: scoreboard of expected bus requests and grant order,
// inline zero/multi-wait slave, reset, timeout, stale-request and fairness checks.
module tb_mem_bus_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req, dm_req, dm_we, bus_ack;
  logic [31:0] if_addr, dm_addr, dm_wdata, bus_rdata;
  logic [3:0]  dm_sel;
  logic [31:0] if_rdata, dm_rdata, bus_addr, bus_wdata;
  logic        if_ack, dm_ack, bus_cyc, bus_stb, bus_we, bus_err, stallreq_if, stallreq_mem;
  logic [3:0]  bus_sel;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] gnt_q[$];
  int          total = 0;
  int          passed = 0;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_sel(dm_sel), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we), .bus_sel(bus_sel),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .bus_err(bus_err),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cyc"},   {31'd0, bus_cyc}, 0);
    chk({tag, "_stb"},   {31'd0, bus_stb}, 0);
    chk({tag, "_we"},    {31'd0, bus_we},  0);
    chk({tag, "_err"},   {31'd0, bus_err}, 0);
    chk({tag, "_ifack"}, {31'd0, if_ack},  0);
    chk({tag, "_dmack"}, {31'd0, dm_ack},  0);
    chk({tag, "_addr"},  bus_addr,  0);
    chk({tag, "_wdata"}, bus_wdata, 0);
    chk({tag, "_sel"},   {28'd0, bus_sel}, 0);
    chk({tag, "_ifrd"},  if_rdata,  0);
    chk({tag, "_dmrd"},  dm_rdata,  0);
  endtask

  // One complete transaction from one requester, with an inline slave model.
  task automatic txn(input bit dm, input logic [31:0] addr, input logic we, input logic [3:0] sel,
                     input logic [31:0] wd, input logic [31:0] rsp, input int waits, input bit never,
                     input bit stale, input logic [31:0] exp_rd, input bit exp_err);
    exp_t e, cur;
    int   g = -1;
    int   stbcnt = 0;
    int   lat;
    bit   done = 0;
    logic w_ack;
    e.addr  = addr;
    e.we    = dm ? we : 1'b0;
    e.sel   = dm ? sel : 4'hF;
    e.wdata = wd;
    exp_q.push_back(e);
    cur = e;
    if (dm) begin
      dm_req = 1; dm_we = we; dm_sel = sel; dm_addr = addr; dm_wdata = wd;
    end else begin
      if_req = 1; if_addr = addr;
    end
    lat = never ? TO : waits + 1;
    for (int t = 0; t < 40 && !done; t++) begin
      step();
      w_ack = dm ? dm_ack : if_ack;
      if (w_ack) begin
        done = 1;
        chk("ack_latency", t - g, lat);
        chk("stb_cycles", stbcnt, lat);
        chk("stb_dropped", {31'd0, bus_stb}, 0);
        chk("rdata", dm ? dm_rdata : if_rdata, exp_rd);
        chk("err", {31'd0, bus_err}, {31'd0, exp_err});
        chk("stall_at_ack", {31'd0, dm ? stallreq_mem : stallreq_if}, 0);
      end else begin
        if (bus_stb) begin
          if (g < 0) begin
            g = t;
            cur = exp_q.pop_front();
            chk("grant_addr", bus_addr, cur.addr);
            chk("grant_we", {31'd0, bus_we}, {31'd0, cur.we});
            chk("grant_sel", {28'd0, bus_sel}, {28'd0, cur.sel});
            chk("grant_cyc", {31'd0, bus_cyc}, 1);
            chk("stall_pend", {31'd0, dm ? stallreq_mem : stallreq_if}, 1);
            if (cur.we) chk("grant_wdata", bus_wdata, cur.wdata);
          end else begin
            chk("stable_addr", bus_addr, cur.addr);
            if (cur.we) chk("stable_wdata", bus_wdata, cur.wdata);
          end
          stbcnt++;
          if (!never && stbcnt > waits) begin
            bus_ack = 1; bus_rdata = rsp;
          end else begin
            bus_ack = 0; bus_rdata = $urandom;
          end
        end else begin
          bus_ack = 0;
        end
      end
    end
    if (!done) chk("ack_timeout", 0, 1);
    bus_ack = 0;
    if (!stale) begin
      if (dm) dm_req = 0; else if_req = 0;
    end
    step();
    chk("ack_pulse_end", {31'd0, dm ? dm_ack : if_ack}, 0);
    chk("err_pulse_end", {31'd0, bus_err}, 0);
    if (dm) dm_req = 0; else if_req = 0;
    step();
    chk("no_regrant", {31'd0, bus_stb}, 0);
    step();
    chk("still_idle", {31'd0, bus_stb}, 0);
  endtask

  initial begin
    int          rdm, rif, ngr, w;
    bit          redm, reif, prev_stb;
    logic [31:0] eg;
    if_req = 0; dm_req = 0; dm_we = 0; bus_ack = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0; dm_sel = 0; bus_rdata = 0;

    repeat (2) step();
    chk_zero("rst");
    rst = 1;
    step();

    txn(0, 32'h100,  0, 4'hF,    32'h0,        32'h34011100, 0, 0, 0, 32'h34011100, 0);
    txn(1, 32'h40,   0, 4'hF,    32'h0,        32'hCAFEF00D, 0, 0, 0, 32'hCAFEF00D, 0);
    txn(1, 32'h2000, 1, 4'b0011, 32'hDEADBEEF, 32'h12345678, 3, 0, 0, 32'hCAFEF00D, 0);
    txn(1, 32'h80,   0, 4'hF,    32'h0,        32'h0,        0, 1, 0, 32'h0,        1);
    txn(0, 32'h104,  0, 4'hF,    32'h0,        32'h00000013, 0, 0, 0, 32'h00000013, 0);
    txn(1, 32'h44,   0, 4'hF,    32'h0,        32'h55AA55AA, 0, 0, 1, 32'h55AA55AA, 0);

    // Reset in the middle of a waiting fetch, with a dm request pending.
    if_req = 1; if_addr = 32'h500; bus_ack = 0;
    step();
    chk("mid_grant", {31'd0, bus_stb}, 1);
    step();
    dm_req = 1; dm_addr = 32'h300; dm_we = 0; dm_sel = 4'hF;
    #2 rst = 0;
    #1;
    chk_zero("rst_mid");
    step();
    step();
    chk("rst_hold_stb", {31'd0, bus_stb}, 0);
    rst = 1;

    // Both requesters held: grants must alternate starting with dm.
    gnt_q.push_back(32'h300); gnt_q.push_back(32'h500);
    gnt_q.push_back(32'h300); gnt_q.push_back(32'h500);
    rdm = 0; rif = 0; ngr = 0; redm = 0; reif = 0; prev_stb = 0;
    for (int t = 1; t <= 60 && ngr < 4; t++) begin
      step();
      if (redm) begin dm_req = 1; rdm = t; redm = 0; end
      if (reif) begin if_req = 1; rif = t; reif = 0; end
      if (dm_ack) begin
        chk("cont_dm_rdata", dm_rdata, 32'h300 ^ 32'hA5A5A5A5);
        dm_req = 0; redm = 1;
      end
      if (if_ack) begin
        chk("cont_if_rdata", if_rdata, 32'h500 ^ 32'hA5A5A5A5);
        if_req = 0; reif = 1;
      end
      if (bus_stb && !prev_stb) begin
        eg = gnt_q.pop_front();
        chk("grant_order", bus_addr, eg);
        w = (bus_addr == 32'h300) ? t - rdm : t - rif;
        chk("wait_le6", {31'd0, w <= 6}, 1);
        ngr++;
      end
      bus_ack = bus_stb;
      bus_rdata = bus_addr ^ 32'hA5A5A5A5;
      prev_stb = bus_stb;
    end
    chk("grant_count", ngr, 4);
    if_req = 0; dm_req = 0;
    repeat (4) begin
      step();
      bus_ack = bus_stb;
    end
    bus_ack = 0;
    step();
    chk("final_idle", {31'd0, bus_stb}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
